// File: rtl/sim_mem_pkg.sv
// Shared types and widths for the simulated-memory lane arbiter.
// The request struct carries a source field sized for the largest supported lane count.
package sim_mem_pkg;

    localparam int SIMMEM_DATA_WIDTH    = 64;
    localparam int SIMMEM_LOGSIZE_WIDTH = 3;
    localparam int MAX_NUM_LANES        = 16;
    localparam int SIMMEM_SRC_W         = $clog2(MAX_NUM_LANES);

    typedef struct packed {
        logic [SIMMEM_DATA_WIDTH-1:0]    address;
        logic                            is_store;
        logic [SIMMEM_LOGSIZE_WIDTH-1:0] size;
        logic [SIMMEM_DATA_WIDTH-1:0]    data;
        logic [SIMMEM_SRC_W-1:0]         source;
    } sim_mem_req_t;

    // Width of a lane index; a single lane still needs a 1-bit tag.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_mem_lane_arbiter_if.sv
// Lane-side and memory-side signal bundle of the lane arbiter.
// The arbiter uses the slave view; a lane/memory driver uses the master view.
interface sim_mem_lane_arbiter_if
    import sim_mem_pkg::*;
#(
    parameter int NUM_LANES = 4
) ();

    localparam int SRC_W = src_width(NUM_LANES);
    localparam int DW    = SIMMEM_DATA_WIDTH;
    localparam int LW    = SIMMEM_LOGSIZE_WIDTH;

    logic [NUM_LANES-1:0]    a_valid;
    logic [NUM_LANES-1:0]    a_ready;
    logic [DW*NUM_LANES-1:0] a_address;
    logic [NUM_LANES-1:0]    a_is_store;
    logic [LW*NUM_LANES-1:0] a_size;
    logic [DW*NUM_LANES-1:0] a_data;
    logic [NUM_LANES-1:0]    d_valid;
    logic [NUM_LANES-1:0]    d_ready;
    logic [DW*NUM_LANES-1:0] d_data;

    logic                    mem_a_valid;
    logic                    mem_a_ready;
    logic [DW-1:0]           mem_a_address;
    logic                    mem_a_is_store;
    logic [LW-1:0]           mem_a_size;
    logic [DW-1:0]           mem_a_data;
    logic [SRC_W-1:0]        mem_a_source;
    logic                    mem_d_valid;
    logic                    mem_d_ready;
    logic [SRC_W-1:0]        mem_d_source;
    logic [DW-1:0]           mem_d_data;

    modport slave (
        input  a_valid, a_address, a_is_store, a_size, a_data, d_ready,
        input  mem_a_ready, mem_d_valid, mem_d_source, mem_d_data,
        output a_ready, d_valid, d_data,
        output mem_a_valid, mem_a_address, mem_a_is_store, mem_a_size, mem_a_data,
        output mem_a_source, mem_d_ready
    );

    modport master (
        output a_valid, a_address, a_is_store, a_size, a_data, d_ready,
        output mem_a_ready, mem_d_valid, mem_d_source, mem_d_data,
        input  a_ready, d_valid, d_data,
        input  mem_a_valid, mem_a_address, mem_a_is_store, mem_a_size, mem_a_data,
        input  mem_a_source, mem_d_ready
    );

endinterface

// File: rtl/sim_mem_lane_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
// The pointer moves past the granted index only when the caller advances.
module rr_arbiter
    import sim_mem_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = src_width(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;

    always_comb begin
        int j;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_reg) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && grant_valid) begin
            ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/sim_mem_lane_arbiter.sv
// Shares one simulated-memory request port among lanes: round-robin into a registered slot,
// per-lane in-flight caps, and response routing by source tag.
module sim_mem_lane_arbiter
    import sim_mem_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int LANE_MAX_INFL = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    sim_mem_lane_arbiter_if.slave  bus
);

    localparam int SRC_W = src_width(NUM_LANES);
    localparam int DW    = SIMMEM_DATA_WIDTH;
    localparam int LW    = SIMMEM_LOGSIZE_WIDTH;
    localparam int CW    = $clog2(LANE_MAX_INFL + 1);

    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] grant;
    logic [NUM_LANES-1:0] accept;
    logic [NUM_LANES-1:0] src_hit;
    logic [NUM_LANES-1:0] infl_pos;
    logic [NUM_LANES-1:0] hit_pos;
    logic [NUM_LANES-1:0] deliver;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 load;

    sim_mem_req_t         sel_req;
    sim_mem_req_t         slot_reg;
    logic                 slot_valid_reg;
    logic                 unused_src_bits;

    rr_arbiter #(
        .N (NUM_LANES)
    ) u_rr_arbiter (
        .clock       (clock),
        .reset       (reset),
        .req         (eligible),
        .advance     (load),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The slot refills in the same cycle it drains, giving one request per cycle.
    assign load        = reset && grant_valid && (!slot_valid_reg || bus.mem_a_ready);
    assign accept      = {NUM_LANES{load}} & grant;
    assign bus.a_ready = accept;

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                sel_req.address  = bus.a_address[i*DW +: DW];
                sel_req.is_store = bus.a_is_store[i];
                sel_req.size     = bus.a_size[i*LW +: LW];
                sel_req.data     = bus.a_data[i*DW +: DW];
            end
        end
        sel_req.source = SIMMEM_SRC_W'(grant_idx);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid_reg <= 1'b0;
            slot_reg       <= '0;
        end else if (load) begin
            slot_valid_reg <= 1'b1;
            slot_reg       <= sel_req;
        end else if (bus.mem_a_ready) begin
            slot_valid_reg <= 1'b0;
        end
    end

    assign bus.mem_a_valid    = slot_valid_reg;
    assign bus.mem_a_address  = slot_reg.address;
    assign bus.mem_a_is_store = slot_reg.is_store;
    assign bus.mem_a_size     = slot_reg.size;
    assign bus.mem_a_data     = slot_reg.data;
    assign bus.mem_a_source   = slot_reg.source[SRC_W-1:0];
    assign unused_src_bits    = ^slot_reg.source;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CW-1:0] infl_reg;

            assign infl_pos[gi] = (infl_reg != '0);
            assign eligible[gi] = bus.a_valid[gi] && (infl_reg < CW'(LANE_MAX_INFL));
            assign src_hit[gi]  = (bus.mem_d_source == SRC_W'(gi));
            assign deliver[gi]  = bus.d_valid[gi] && bus.d_ready[gi];

            // Accept and delivery in the same cycle cancel out.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    infl_reg <= '0;
                end else if (accept[gi] && !deliver[gi]) begin
                    infl_reg <= infl_reg + 1'b1;
                end else if (!accept[gi] && deliver[gi]) begin
                    infl_reg <= infl_reg - 1'b1;
                end
            end
        end
    endgenerate

    // Responses for lanes with nothing outstanding (stale or bad source) are swallowed.
    assign hit_pos         = src_hit & infl_pos;
    assign bus.d_valid     = {NUM_LANES{bus.mem_d_valid}} & hit_pos;
    assign bus.mem_d_ready = (|hit_pos) ? |(hit_pos & bus.d_ready) : 1'b1;
    assign bus.d_data      = {NUM_LANES{bus.mem_d_data}};

endmodule

// File: tb/tb_sim_mem_lane_arbiter.sv
// Self-checking bench for sim_mem_lane_arbiter: request scoreboard plus directed scenarios
// for rotation, in-flight cap, back-pressure, response routing and reset.
module tb_sim_mem_lane_arbiter;
    import sim_mem_pkg::*;

    localparam int NL    = 4;
    localparam int DW    = SIMMEM_DATA_WIDTH;
    localparam int LW    = SIMMEM_LOGSIZE_WIDTH;
    localparam int SRC_W = src_width(NL);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sim_mem_lane_arbiter_if #(.NUM_LANES(NL)) bus ();

    sim_mem_lane_arbiter #(
        .NUM_LANES     (NL),
        .LANE_MAX_INFL (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    int           lane_seq [NL] = '{default: 0};
    int           lane_acc [NL] = '{default: 0};
    bit           auto_resp = 1'b0;
    sim_mem_req_t exp_q [$];
    int           resp_q [$];
    int           src_log [$];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic sim_mem_req_t lane_req(input int lane, input int seq);
        sim_mem_req_t r;
        r.address  = 64'h1000_0000 * 64'(lane + 1) + 64'(seq) * 64'd8;
        r.data     = ~r.address ^ 64'(seq * 3);
        r.is_store = seq[0];
        r.size     = LW'(seq % 4);
        r.source   = SIMMEM_SRC_W'(lane);
        return r;
    endfunction

    function automatic logic [DW-1:0] resp_data(input int src);
        return 64'hD00D_0000_0000_0000 | 64'(src);
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NL; i++) begin
            sim_mem_req_t r;
            r = lane_req(i, lane_seq[i]);
            bus.a_address[i*DW +: DW] = r.address;
            bus.a_is_store[i]         = r.is_store;
            bus.a_size[i*LW +: LW]    = r.size;
            bus.a_data[i*DW +: DW]    = r.data;
        end
    endtask

    task automatic set_resp(input logic v, input int src);
        bus.mem_d_valid  = v;
        bus.mem_d_source = SRC_W'(src);
        bus.mem_d_data   = resp_data(src);
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        drive_payload();
        if (auto_resp) begin
            if (resp_q.size() > 0) set_resp(1'b1, resp_q[0]);
            else                   set_resp(1'b0, 0);
        end
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        auto_resp     = 1'b0;
        bus.a_valid   = '0;
        bus.d_ready   = '1;
        bus.mem_a_ready = 1'b0;
        set_resp(1'b0, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Scoreboard: push on lane accept, pop and compare on memory-side fire.
    always @(negedge clock) begin
        sim_mem_req_t got;
        int           src;
        if (!reset) begin
            exp_q.delete();
            resp_q.delete();
        end else begin
            check("a_ready_onehot", 160'($countones(bus.a_ready) <= 1), 160'(1));
            if (bus.mem_a_valid && bus.mem_a_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_req", 160'(0), 160'(1));
                end else begin
                    got.address  = bus.mem_a_address;
                    got.is_store = bus.mem_a_is_store;
                    got.size     = bus.mem_a_size;
                    got.data     = bus.mem_a_data;
                    got.source   = SIMMEM_SRC_W'(bus.mem_a_source);
                    check("mem_a_req", 160'(got), 160'(exp_q.pop_front()));
                    src_log.push_back(int'(bus.mem_a_source));
                    if (auto_resp) resp_q.push_back(int'(bus.mem_a_source));
                end
            end
            if (auto_resp && bus.mem_d_valid && bus.mem_d_ready && resp_q.size() > 0) begin
                src = resp_q.pop_front();
                check("auto_d_valid", 160'(bus.d_valid[src]), 160'(1));
                check("auto_d_data", 160'(bus.d_data[src*DW +: DW]), 160'(resp_data(src)));
            end
            for (int i = 0; i < NL; i++) begin
                if (bus.a_ready[i]) begin
                    check("a_ready_needs_valid", 160'(bus.a_valid[i]), 160'(1));
                    exp_q.push_back(lane_req(i, lane_seq[i]));
                    lane_seq[i]++;
                    lane_acc[i]++;
                end
            end
        end
    end

    initial begin
        int           base;
        int           acc0;
        logic [DW-1:0] addr0;
        logic [DW-1:0] addr1;

        // Reset state, with active-looking inputs to show they are ignored.
        reset       = 1'b0;
        drive_payload();
        bus.a_valid = '1;
        bus.d_ready = '1;
        bus.mem_a_ready = 1'b1;
        set_resp(1'b1, 0);
        #2;
        check("rst_mem_a_valid", 160'(bus.mem_a_valid), 160'(0));
        check("rst_mem_a_addr", 160'(bus.mem_a_address), 160'(0));
        check("rst_mem_a_source", 160'(bus.mem_a_source), 160'(0));
        check("rst_a_ready", 160'(bus.a_ready), 160'(0));
        check("rst_d_valid", 160'(bus.d_valid), 160'(0));
        check("rst_mem_d_ready", 160'(bus.mem_d_ready), 160'(1));
        apply_reset();

        // Round-robin rotation at full throughput with instant responses.
        base = src_log.size();
        bus.a_valid = 4'b1111;
        bus.mem_a_ready = 1'b1;
        auto_resp   = 1'b1;
        #2;
        check("rr_first_grant", 160'(bus.a_ready), 160'(4'b0001));
        check("rr_latency_pre", 160'(bus.mem_a_valid), 160'(0));
        tick();
        #2;
        check("rr_latency_post", 160'(bus.mem_a_valid), 160'(1));
        check("rr_second_grant", 160'(bus.a_ready), 160'(4'b0010));
        for (int c = 0; c < 10; c++) tick();
        check("rr_fire_count", 160'(src_log.size() - base >= 8), 160'(1));
        for (int k = 0; k < 8; k++) begin
            if (base + k < src_log.size())
                check("rr_source_order", 160'(src_log[base + k]), 160'(k % 4));
        end
        bus.a_valid = '0;
        for (int c = 0; c < 4; c++) tick();
        apply_reset();

        // In-flight cap on lane 2 with responses withheld.
        acc0 = lane_acc[2];
        bus.a_valid = 4'b0100;
        bus.mem_a_ready = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        #2;
        check("cap_accepts", 160'(lane_acc[2] - acc0), 160'(4));
        check("cap_a_ready_low", 160'(bus.a_ready), 160'(0));
        tick();
        set_resp(1'b1, 2);
        #2;
        check("cap_d_valid", 160'(bus.d_valid), 160'(4'b0100));
        check("cap_mem_d_ready", 160'(bus.mem_d_ready), 160'(1));
        check("cap_still_full", 160'(bus.a_ready), 160'(0));
        tick();
        set_resp(1'b0, 0);
        #2;
        check("cap_reopen", 160'(bus.a_ready), 160'(4'b0100));
        bus.a_valid = '0;
        tick();
        apply_reset();

        // Back-pressure: slot held stable, then drain and reload in one cycle.
        addr0 = lane_req(0, lane_seq[0]).address;
        addr1 = lane_req(1, lane_seq[1]).address;
        bus.a_valid = 4'b0011;
        bus.mem_a_ready = 1'b0;
        #2;
        check("bp_first_grant", 160'(bus.a_ready), 160'(4'b0001));
        for (int c = 0; c < 5; c++) begin
            tick();
            #2;
            check("bp_no_a_ready", 160'(bus.a_ready), 160'(0));
            check("bp_valid_held", 160'(bus.mem_a_valid), 160'(1));
            check("bp_addr_held", 160'(bus.mem_a_address), 160'(addr0));
            check("bp_src_held", 160'(bus.mem_a_source), 160'(0));
        end
        bus.mem_a_ready = 1'b1;
        #1;
        check("bp_reload_grant", 160'(bus.a_ready), 160'(4'b0010));
        tick();
        bus.a_valid = '0;
        #2;
        check("bp_reload_src", 160'(bus.mem_a_source), 160'(1));
        check("bp_reload_addr", 160'(bus.mem_a_address), 160'(addr1));
        tick();
        tick();
        apply_reset();

        // Response stalled by d_ready on lane 1.
        bus.a_valid = 4'b0010;
        bus.mem_a_ready = 1'b1;
        tick();
        bus.a_valid = '0;
        tick();
        set_resp(1'b1, 1);
        bus.d_ready = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("stall_d_valid", 160'(bus.d_valid), 160'(4'b0010));
            check("stall_mem_d_ready", 160'(bus.mem_d_ready), 160'(0));
            tick();
        end
        bus.d_ready = '1;
        #1;
        check("stall_release_ready", 160'(bus.mem_d_ready), 160'(1));
        check("stall_release_valid", 160'(bus.d_valid), 160'(4'b0010));
        tick();
        #2;
        check("stall_done_valid", 160'(bus.d_valid), 160'(0));
        check("stall_done_ready", 160'(bus.mem_d_ready), 160'(1));
        set_resp(1'b0, 0);
        apply_reset();

        // Same-cycle accept and response on lane 0 keeps the count at 2.
        bus.a_valid = 4'b0001;
        bus.mem_a_ready = 1'b1;
        tick();
        tick();
        set_resp(1'b1, 0);
        #2;
        check("same_accept", 160'(bus.a_ready), 160'(4'b0001));
        check("same_deliver", 160'(bus.d_valid), 160'(4'b0001));
        tick();
        bus.a_valid = '0;
        #2;
        check("same_resp_1", 160'(bus.d_valid), 160'(4'b0001));
        tick();
        #2;
        check("same_resp_2", 160'(bus.d_valid), 160'(4'b0001));
        tick();
        #2;
        check("same_resp_3_drop", 160'(bus.d_valid), 160'(0));
        check("same_resp_3_ready", 160'(bus.mem_d_ready), 160'(1));
        set_resp(1'b0, 0);
        apply_reset();

        // Reset mid-transaction with lane 3 holding three requests.
        bus.a_valid = 4'b1000;
        bus.mem_a_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.a_valid = '0;
        bus.mem_a_ready = 1'b0;
        #2;
        check("mid_slot_full", 160'(bus.mem_a_valid), 160'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 160'(bus.mem_a_valid), 160'(0));
        check("mid_rst_a_ready", 160'(bus.a_ready), 160'(0));
        tick();
        tick();
        reset = 1'b1;
        bus.d_ready = '1;
        set_resp(1'b1, 3);
        #2;
        check("stale_d_valid", 160'(bus.d_valid), 160'(0));
        check("stale_mem_d_ready", 160'(bus.mem_d_ready), 160'(1));
        tick();
        set_resp(1'b0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
